// File: rtl/game_sequencer.sv
// game_sequencer: session controller for the rhythm game.
// Runs a session (IDLE, COUNTDOWN, PLAY, RESULT), divides the clock into game ticks, and prefetches
// timestamped pattern entries into a one-entry buffer. Each entry is issued when game time reaches
// its timestamp.
//
// Ports:
//   clock_i            system clock
//   reset_i            asynchronous active-high reset
//   start_i, abort_i   single-cycle session requests (abort has priority)
//   entry_valid_i      pattern source has an entry
//   entry_data_i       {timestamp[9:0], pattern[7:0]}; timestamp 10'h3FF marks the end
//   entry_ready_o      an entry is accepted this cycle
//   state_o            0 IDLE, 1 COUNTDOWN, 2 PLAY, 3 RESULT
//   game_time_o        current game tick
//   tick_o             one-cycle game-tick pulse
//   countdown_o        remaining countdown ticks
//   pattern_o          last issued pattern, with pattern_strobe_o pulsing on each update
//   late_count_o       entries issued after their timestamp (saturating)
//   done_o             high while in RESULT
module game_sequencer #(
  parameter int unsigned TICK_DIV        = 1000000,
  parameter int unsigned COUNTDOWN_TICKS = 30,
  parameter int unsigned GAME_LEN        = 1000
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        entry_valid_i,
  input  logic [17:0] entry_data_i,
  output logic        entry_ready_o,
  output logic [1:0]  state_o,
  output logic [9:0]  game_time_o,
  output logic        tick_o,
  output logic [4:0]  countdown_o,
  output logic [7:0]  pattern_o,
  output logic        pattern_strobe_o,
  output logic [7:0]  late_count_o,
  output logic        done_o
);

  localparam logic [1:0] StIdle      = 2'd0;
  localparam logic [1:0] StCountdown = 2'd1;
  localparam logic [1:0] StPlay      = 2'd2;
  localparam logic [1:0] StResult    = 2'd3;

  localparam int unsigned     DivW     = $clog2(TICK_DIV);
  localparam logic [DivW-1:0] DivMax   = DivW'(TICK_DIV - 1);
  localparam logic [4:0]      CdLoad   = 5'(COUNTDOWN_TICKS);
  localparam logic [9:0]      LastTick = 10'(GAME_LEN - 1);
  localparam logic [9:0]      EndMark  = 10'h3FF;

  logic [1:0]      state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [9:0]      game_time_q, game_time_d;
  logic [4:0]      countdown_q, countdown_d;
  logic [7:0]      pattern_q, pattern_d;
  logic            strobe_q, strobe_d;
  logic [7:0]      late_q, late_d;
  logic            done_q, done_d;
  logic            buf_full_q, buf_full_d;
  logic [9:0]      buf_ts_q, buf_ts_d;
  logic [7:0]      buf_pat_q, buf_pat_d;

  logic running;
  logic tick;
  logic ready;

  always_comb begin
    running = (state_q == StCountdown) || (state_q == StPlay);
    tick    = running && (div_q == DivMax);
    ready   = running && !buf_full_q;

    state_d     = state_q;
    div_d       = div_q;
    game_time_d = game_time_q;
    countdown_d = countdown_q;
    pattern_d   = pattern_q;
    strobe_d    = 1'b0;
    late_d      = late_q;
    buf_full_d  = buf_full_q;
    buf_ts_d    = buf_ts_q;
    buf_pat_d   = buf_pat_q;

    // Divider only runs while a session is live; RESULT freezes it.
    if (running) begin
      div_d = tick ? '0 : div_q + DivW'(1);
    end

    // Transfer needs an empty buffer, so it never collides with an issue.
    if (entry_valid_i && ready) begin
      buf_full_d = 1'b1;
      buf_ts_d   = entry_data_i[17:8];
      buf_pat_d  = entry_data_i[7:0];
    end

    unique case (state_q)
      StIdle, StResult: begin
        if (start_i) begin
          state_d     = StCountdown;
          countdown_d = CdLoad;
          game_time_d = '0;
          pattern_d   = '0;
          late_d      = '0;
          div_d       = '0;
          buf_full_d  = 1'b0;
        end
      end
      StCountdown: begin
        if (tick) begin
          countdown_d = countdown_q - 5'd1;
          if (countdown_q == 5'd1) begin
            state_d     = StPlay;
            countdown_d = '0;
            game_time_d = '0;
          end
        end
      end
      StPlay: begin
        if (tick) begin
          if (game_time_q == LastTick) begin
            state_d = StResult;
          end else begin
            game_time_d = game_time_q + 10'd1;
          end
        end
        // The end marker can never satisfy ts <= game_time, so it is consumed on sight.
        if (buf_full_q) begin
          if (buf_ts_q == EndMark) begin
            buf_full_d = 1'b0;
            state_d    = StResult;
          end else if (buf_ts_q <= game_time_q) begin
            pattern_d  = buf_pat_q;
            strobe_d   = 1'b1;
            buf_full_d = 1'b0;
            if ((buf_ts_q < game_time_q) && (late_q != 8'hFF)) begin
              late_d = late_q + 8'd1;
            end
          end
        end
      end
    endcase

    // Abort overrides everything; session results stay visible.
    if (abort_i) begin
      state_d     = StIdle;
      div_d       = '0;
      game_time_d = game_time_q;
      countdown_d = countdown_q;
      pattern_d   = pattern_q;
      strobe_d    = 1'b0;
      late_d      = late_q;
      buf_full_d  = 1'b0;
    end

    done_d = (state_d == StResult);
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      div_q       <= '0;
      game_time_q <= '0;
      countdown_q <= '0;
      pattern_q   <= '0;
      strobe_q    <= 1'b0;
      late_q      <= '0;
      done_q      <= 1'b0;
      buf_full_q  <= 1'b0;
      buf_ts_q    <= '0;
      buf_pat_q   <= '0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      game_time_q <= game_time_d;
      countdown_q <= countdown_d;
      pattern_q   <= pattern_d;
      strobe_q    <= strobe_d;
      late_q      <= late_d;
      done_q      <= done_d;
      buf_full_q  <= buf_full_d;
      buf_ts_q    <= buf_ts_d;
      buf_pat_q   <= buf_pat_d;
    end
  end

  assign entry_ready_o    = ready;
  assign state_o          = state_q;
  assign game_time_o      = game_time_q;
  assign tick_o           = tick;
  assign countdown_o      = countdown_q;
  assign pattern_o        = pattern_q;
  assign pattern_strobe_o = strobe_q;
  assign late_count_o     = late_q;
  assign done_o           = done_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed bench for game_sequencer with TICK_DIV=4, COUNTDOWN_TICKS=3,
// GAME_LEN=20. Expected issues go into a scoreboard queue; a monitor pops one per pattern strobe.
module tb_game_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        entry_valid = 1'b0;
  logic [17:0] entry_data = '0;
  logic        entry_ready;
  logic [1:0]  state;
  logic [9:0]  game_time;
  logic        tick;
  logic [4:0]  countdown;
  logic [7:0]  pattern;
  logic        pattern_strobe;
  logic [7:0]  late_count;
  logic        done;

  int checks = 0;
  int errors = 0;
  int t = 0;

  typedef struct {
    logic [7:0] pat;
    logic [7:0] late;
    logic [9:0] gt;
  } exp_t;

  exp_t sb_q[$];

  game_sequencer #(
    .TICK_DIV       (4),
    .COUNTDOWN_TICKS(3),
    .GAME_LEN       (20)
  ) dut (
    .clock_i         (clock),
    .reset_i         (reset),
    .start_i         (start),
    .abort_i         (abort),
    .entry_valid_i   (entry_valid),
    .entry_data_i    (entry_data),
    .entry_ready_o   (entry_ready),
    .state_o         (state),
    .game_time_o     (game_time),
    .tick_o          (tick),
    .countdown_o     (countdown),
    .pattern_o       (pattern),
    .pattern_strobe_o(pattern_strobe),
    .late_count_o    (late_count),
    .done_o          (done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step_to(input int n);
    while (t < n) begin
      @(negedge clock);
      t++;
    end
  endtask

  task automatic push_exp(input logic [7:0] pat, input logic [7:0] late, input logic [9:0] gt);
    exp_t e;
    e.pat  = pat;
    e.late = late;
    e.gt   = gt;
    sb_q.push_back(e);
  endtask

  // Start pulse issued at the current negedge, which becomes cycle 0 of the session.
  task automatic begin_session();
    start = 1'b1;
    t = 0;
    step_to(1);
    start = 1'b0;
  endtask

  // Scoreboard monitor.
  always @(negedge clock) begin
    if (!reset && pattern_strobe) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: pattern %0h with no expected issue", pattern);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("strobe_pattern", 32'(pattern), 32'(e.pat));
        chk("strobe_late_count", 32'(late_count), 32'(e.late));
        chk("strobe_game_time", 32'(game_time), 32'(e.gt));
      end
    end
  end

  initial begin
    @(negedge clock);
    chk("reset_state", 32'(state), 0);
    chk("reset_game_time", 32'(game_time), 0);
    chk("reset_countdown", 32'(countdown), 0);
    chk("reset_pattern", 32'(pattern), 0);
    chk("reset_late", 32'(late_count), 0);
    chk("reset_ready", 32'(entry_ready), 0);
    chk("reset_done", 32'(done), 0);
    reset = 1'b0;
    @(negedge clock);

    // Session 1: countdown, prefetched on-time entries, natural end at GAME_LEN.
    begin_session();
    chk("s1_state_cd", 32'(state), 1);
    chk("s1_countdown3", 32'(countdown), 3);
    chk("s1_ready_cd", 32'(entry_ready), 1);
    entry_valid = 1'b1;
    entry_data  = {10'd2, 8'hA5};
    push_exp(8'hA5, 8'd0, 10'd2);
    step_to(2);
    chk("s1_ready_full", 32'(entry_ready), 0);
    entry_data = {10'd5, 8'h3C};
    push_exp(8'h3C, 8'd0, 10'd5);
    step_to(4);
    chk("s1_first_tick", 32'(tick), 1);
    chk("s1_countdown3_hold", 32'(countdown), 3);
    step_to(5);
    chk("s1_countdown2", 32'(countdown), 2);
    chk("s1_tick_low", 32'(tick), 0);
    step_to(9);
    chk("s1_countdown1", 32'(countdown), 1);
    step_to(12);
    chk("s1_still_cd", 32'(state), 1);
    step_to(13);
    chk("s1_state_play", 32'(state), 2);
    chk("s1_gt0", 32'(game_time), 0);
    chk("s1_countdown0", 32'(countdown), 0);
    step_to(21);
    chk("s1_gt2", 32'(game_time), 2);
    step_to(22);
    chk("s1_ready_after_issue", 32'(entry_ready), 1);
    step_to(23);
    entry_valid = 1'b0;
    chk("s1_ready_refilled", 32'(entry_ready), 0);
    step_to(35);
    chk("s1_pattern_3c", 32'(pattern), 32'h3C);
    chk("s1_late0", 32'(late_count), 0);
    step_to(92);
    chk("s1_play_at_19", 32'(state), 2);
    chk("s1_gt19", 32'(game_time), 19);
    step_to(93);
    chk("s1_result", 32'(state), 3);
    chk("s1_done", 32'(done), 1);
    chk("s1_gt_hold", 32'(game_time), 19);
    chk("s1_ready_result", 32'(entry_ready), 0);
    step_to(98);
    chk("s1_no_tick_result", 32'(tick), 0);

    // Session 2 (started from RESULT): late entry, then end marker.
    begin_session();
    chk("s2_state_cd", 32'(state), 1);
    chk("s2_pattern_clr", 32'(pattern), 0);
    chk("s2_gt_clr", 32'(game_time), 0);
    step_to(29);
    chk("s2_gt4", 32'(game_time), 4);
    chk("s2_ready", 32'(entry_ready), 1);
    entry_valid = 1'b1;
    entry_data  = {10'd1, 8'h0F};
    push_exp(8'h0F, 8'd1, 10'd4);
    step_to(30);
    entry_valid = 1'b0;
    step_to(32);
    chk("s2_late1", 32'(late_count), 1);
    step_to(41);
    chk("s2_gt7", 32'(game_time), 7);
    entry_valid = 1'b1;
    entry_data  = {10'h3FF, 8'hEE};
    step_to(42);
    entry_valid = 1'b0;
    chk("s2_play_before_marker", 32'(state), 2);
    step_to(43);
    chk("s2_marker_result", 32'(state), 3);
    chk("s2_marker_done", 32'(done), 1);
    chk("s2_marker_pattern", 32'(pattern), 32'h0F);
    chk("s2_marker_gt", 32'(game_time), 7);
    step_to(45);

    // Session 3: abort mid-PLAY with a full buffer.
    begin_session();
    chk("s3_late_clr", 32'(late_count), 0);
    entry_valid = 1'b1;
    entry_data  = {10'd0, 8'h5A};
    push_exp(8'h5A, 8'd0, 10'd0);
    step_to(2);
    entry_valid = 1'b0;
    step_to(14);
    chk("s3_ready", 32'(entry_ready), 1);
    entry_valid = 1'b1;
    entry_data  = {10'd10, 8'h55};
    step_to(15);
    entry_valid = 1'b0;
    chk("s3_full", 32'(entry_ready), 0);
    step_to(16);
    abort = 1'b1;
    step_to(17);
    abort = 1'b0;
    chk("s3_abort_idle", 32'(state), 0);
    chk("s3_abort_ready", 32'(entry_ready), 0);
    chk("s3_abort_pattern", 32'(pattern), 32'h5A);
    chk("s3_abort_done", 32'(done), 0);
    step_to(18);
    start = 1'b1;
    abort = 1'b1;
    step_to(19);
    start = 1'b0;
    abort = 1'b0;
    chk("s3_abort_wins", 32'(state), 0);
    chk("s3_abort_wins_cd", 32'(countdown), 0);
    step_to(20);

    // Session 4: asynchronous reset mid-PLAY.
    begin_session();
    entry_valid = 1'b1;
    entry_data  = {10'd0, 8'h77};
    push_exp(8'h77, 8'd0, 10'd0);
    step_to(2);
    entry_valid = 1'b0;
    step_to(20);
    chk("s4_play", 32'(state), 2);
    chk("s4_gt1", 32'(game_time), 1);
    #2 reset = 1'b1;
    #1;
    chk("s4_rst_state", 32'(state), 0);
    chk("s4_rst_gt", 32'(game_time), 0);
    chk("s4_rst_pattern", 32'(pattern), 0);
    chk("s4_rst_cd", 32'(countdown), 0);
    chk("s4_rst_late", 32'(late_count), 0);
    chk("s4_rst_ready", 32'(entry_ready), 0);
    chk("s4_rst_tick", 32'(tick), 0);
    chk("s4_rst_done", 32'(done), 0);
    chk("s4_rst_strobe", 32'(pattern_strobe), 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    chk("scoreboard_drained", 32'(sb_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
